conv1_pool_2x2: RTL and testbench

2x2, stride-2 max-pooling stage directly downstream of the conv1 compute/ReLU stage. It consumes one beat of `NUM_INPUTS` horizontally adjacent ReLU outputs per valid cycle, in raster order across a `ROW_LEN` x `NUM_ROWS` feature map. It holds horizontal maxima of each even row in a line buffer and combines them with the following odd row. It emits `NUM_INPUTS/2` pooled values per odd-row beat to the next LeNet layer.

---
 rtl/conv1_pool_2x2.sv | 140 ++++++++++++++
 tb/tb_conv1_pool_2x2.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/conv1_pool_2x2.sv
// 2x2 stride-2 max-pool on a raster stream of ReLU beats; even rows fill a line buffer, odd rows emit pooled beats.
// Latency: one cycle from an odd-row input beat to its registered output; no backpressure, one beat per cycle.
module conv1_pool_2x2 #(
  parameter int NUM_INPUTS   = 4,
  parameter int INPUT_WIDTH  = 22,
  parameter int OUTPUT_WIDTH = INPUT_WIDTH,
  parameter int ROW_LEN      = 28,
  parameter int NUM_ROWS     = 28
) (
  input  logic                                               conv1_pool_clk,
  input  logic                                               conv1_pool_rst,
  input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]             conv1_pool_in_i,
  input  logic                                               conv1_pool_in_valid_i,
  output logic [NUM_INPUTS/2-1:0][OUTPUT_WIDTH-1:0]          conv1_pool_out_o,
  output logic                                               conv1_pool_out_valid_o,
  output logic                                               conv1_pool_frame_done_o
);

  localparam int BEATS_PER_ROW = ROW_LEN / NUM_INPUTS;
  localparam int POOL_PER_BEAT = NUM_INPUTS / 2;
  localparam int COL_W = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BEATS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_POOL = 1'b1;

  typedef logic [POOL_PER_BEAT-1:0][INPUT_WIDTH-1:0]  hpair_t;
  typedef logic [POOL_PER_BEAT-1:0][OUTPUT_WIDTH-1:0] opair_t;

  logic [0:0]       state_q, state_d;
  logic [COL_W-1:0] col_cnt_q, col_cnt_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  opair_t           out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic             frame_done_q, frame_done_d;
  hpair_t           lb_q [BEATS_PER_ROW];
  hpair_t           lb_d [BEATS_PER_ROW];

  hpair_t h_max;
  hpair_t lb_rd;
  opair_t pooled;
  logic   last_col;
  logic   last_row;

  // Narrower outputs clamp to all-ones rather than wrapping.
  function automatic logic [OUTPUT_WIDTH-1:0] resize_val(input logic [INPUT_WIDTH-1:0] v);
    if ((OUTPUT_WIDTH < INPUT_WIDTH) && ((v >> OUTPUT_WIDTH) != '0)) begin
      resize_val = '1;
    end else begin
      resize_val = OUTPUT_WIDTH'(v);
    end
  endfunction

  assign last_col = (col_cnt_q == LAST_COL);
  assign last_row = (row_cnt_q == LAST_ROW);
  assign lb_rd    = lb_q[col_cnt_q];

  always_comb begin
    h_max  = '0;
    pooled = '0;
    for (int k = 0; k < POOL_PER_BEAT; k++) begin
      h_max[k] = (conv1_pool_in_i[2*k] >= conv1_pool_in_i[2*k+1]) ?
                 conv1_pool_in_i[2*k] : conv1_pool_in_i[2*k+1];
      pooled[k] = resize_val((lb_rd[k] >= h_max[k]) ? lb_rd[k] : h_max[k]);
    end
  end

  always_comb begin
    state_d      = state_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    out_d        = out_q;
    out_vld_d    = 1'b0;
    frame_done_d = 1'b0;
    for (int e = 0; e < BEATS_PER_ROW; e++) begin
      lb_d[e] = lb_q[e];
    end

    if (conv1_pool_in_valid_i) begin
      if (last_col) begin
        col_cnt_d = '0;
        row_cnt_d = last_row ? '0 : row_cnt_q + ROW_W'(1);
      end else begin
        col_cnt_d = col_cnt_q + COL_W'(1);
      end

      case (state_q)
        ST_FILL: begin
          lb_d[col_cnt_q] = h_max;
          if (last_col) begin
            state_d = ST_POOL;
          end
        end
        ST_POOL: begin
          out_d        = pooled;
          out_vld_d    = 1'b1;
          frame_done_d = last_col && last_row;
          if (last_col) begin
            state_d = ST_FILL;
          end
        end
        default: begin
          state_d = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge conv1_pool_clk) begin
    if (conv1_pool_rst) begin
      state_q      <= ST_FILL;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      out_q        <= '0;
      out_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer is never read before a FILL row rewrites it, so it needs no reset.
  always_ff @(posedge conv1_pool_clk) begin
    for (int e = 0; e < BEATS_PER_ROW; e++) begin
      lb_q[e] <= lb_d[e];
    end
  end

  assign conv1_pool_out_o        = out_q;
  assign conv1_pool_out_valid_o  = out_vld_q;
  assign conv1_pool_frame_done_o = frame_done_q;

endmodule

// File: tb/tb_conv1_pool_2x2.sv
// Randomized scoreboard bench for conv1_pool_2x2: an image-level model predicts every pooled beat.
module tb_conv1_pool_2x2;

  localparam int NI  = 4;
  localparam int IW  = 22;
  localparam int OW  = 22;
  localparam int RL  = 28;
  localparam int NR  = 28;
  localparam int BPR = RL / NI;
  localparam int PPB = NI / 2;

  typedef logic [PPB-1:0][OW-1:0] opair_t;
  typedef struct packed {
    opair_t dat;
    logic   done;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NI-1:0][IW-1:0]  in_dat = '0;
  logic                   in_vld = 1'b0;
  opair_t                 out_dat;
  logic                   out_vld;
  logic                   frame_done;

  always #5 clk = ~clk;

  conv1_pool_2x2 #(
    .NUM_INPUTS(NI), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .ROW_LEN(RL), .NUM_ROWS(NR)
  ) dut (
    .conv1_pool_clk(clk),
    .conv1_pool_rst(rst),
    .conv1_pool_in_i(in_dat),
    .conv1_pool_in_valid_i(in_vld),
    .conv1_pool_out_o(out_dat),
    .conv1_pool_out_valid_o(out_vld),
    .conv1_pool_frame_done_o(frame_done)
  );

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned img [NR][RL];
  int          drv_row = 0;
  int          drv_beat = 0;
  int          frames_sent = 0;
  int          done_cnt = 0;
  opair_t      last_out = '0;
  logic        rst_at_edge = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int unsigned max4(input int unsigned a, b, c, d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Window (row pair ending at r, columns c0..c0+1) maximum straight from the image.
  task automatic send_beat();
    exp_t e;
    int   c0;
    for (int i = 0; i < NI; i++) in_dat[i] = IW'(img[drv_row][drv_beat*NI+i]);
    if (drv_row % 2 == 1) begin
      for (int k = 0; k < PPB; k++) begin
        c0 = drv_beat*NI + 2*k;
        e.dat[k] = OW'(max4(img[drv_row-1][c0], img[drv_row-1][c0+1],
                            img[drv_row][c0],   img[drv_row][c0+1]));
      end
      e.done = (drv_row == NR-1) && (drv_beat == BPR-1);
      exp_q.push_back(e);
    end
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    drv_beat++;
    if (drv_beat == BPR) begin
      drv_beat = 0;
      drv_row++;
      if (drv_row == NR) begin
        drv_row = 0;
        frames_sent++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int max_gap);
    for (int b = 0; b < NR*BPR; b++) begin
      send_beat();
      if (max_gap > 0) idle($urandom_range(max_gap, 0));
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      in_vld = 1'b1;
      for (int j = 0; j < NI; j++) in_dat[j] = IW'($urandom_range(1000, 1));
      @(posedge clk); #1;
    end
    rst = 1'b0;
    in_vld = 1'b0;
    drv_row = 0;
    drv_beat = 0;
  endtask

  function automatic void set_ramp();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < RL; c++) img[r][c] = r*RL + c;
  endfunction

  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) begin
      check("reset_out", 64'(out_dat), 64'd0);
      check("reset_vld", 64'(out_vld), 64'd0);
      check("reset_done", 64'(frame_done), 64'd0);
      last_out = '0;
    end else if (out_vld) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_dat), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("pool_data", 64'(out_dat), 64'(e.dat));
        check("frame_done", 64'(frame_done), 64'(e.done));
        last_out = e.dat;
        if (e.done) done_cnt++;
      end
    end else begin
      check("hold_out", 64'(out_dat), 64'(last_out));
      check("done_no_vld", 64'(frame_done), 64'd0);
    end
  end

  initial begin
    do_reset(3);

    set_ramp();
    send_frame(0);

    for (int p = 0; p < 4; p++) begin
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < RL; c++) img[r][c] = 5;
      img[p/2][p%2] = 1000;
      send_frame(0);
    end

    set_ramp();
    send_frame(3);

    for (int r = 0; r < NR; r++)
      for (int c = 0; c < RL; c++) img[r][c] = $urandom_range((1 << IW) - 1, 0);
    send_frame(1);

    set_ramp();
    while (!(drv_row == 13 && drv_beat == 5)) send_beat();
    idle(2);
    do_reset(1);
    send_frame(0);

    send_frame(0);
    send_frame(0);

    idle(5);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("frame_done_count", 64'(done_cnt), 64'(frames_sent));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
